tile_flush_engine: RTL

- Parametrised successor of the fixed 16x32 tile writer.
- Copies a rectangular, optionally clipped, tile from on-chip tile RAM to the framebuffer in system memory.
- Reads tile RAM in the gpu_clk domain, pushes {address, data, byteenable} words through a dual-clock FIFO, and drains the FIFO onto an Avalon-MM write master in the clk domain.
- Adds three things its predecessor lacks: edge clipping (partial tiles), a per-word byte-enable mask, and start-while-busy queueing of one pending job.

---
 rtl/gpu_tile_pkg.sv | 18 +
 rtl/dc_fifo.sv | 82 ++++++++
 rtl/shift_reg.sv | 26 ++
 rtl/tile_addr_gen.sv | 67 ++++++
 rtl/tile_flush_engine.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/gpu_tile_pkg.sv
// Shared types and constants for the tile flush engine.
package gpu_tile_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2,
    S_ROW   = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // FIFO word is {address, byteenable[3:0], data[31:0]}.
  function automatic int fifo_word_w(input int addr_w);
    return addr_w + 36;
  endfunction

endpackage

// File: rtl/dc_fifo.sv
// Dual-clock FIFO, show-ahead read, Gray-coded pointers with two-flop synchronisers.
// Write-side level/empty are derived from the synchronised read pointer, so they
// are pessimistic (over-report occupancy) and lag actual reads by the sync latency.
module dc_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_aclr,
  input  logic             i_wrclk,
  input  logic             i_wrreq,
  input  logic [WIDTH-1:0] i_data,
  output logic [AW:0]      o_wrusedw,
  output logic             o_wrfull,
  output logic             o_wrempty,
  input  logic             i_rdclk,
  input  logic             i_rdreq,
  output logic [WIDTH-1:0] o_q,
  output logic             o_rdempty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wbin, r_wgray, r_rgray_s1, r_rgray_s2;
  logic [AW:0] r_rbin, r_rgray, r_wgray_s1, r_wgray_s2;
  logic [AW:0] w_wbin_nxt, w_rbin_nxt, w_rbin_sync;
  logic        w_push, w_pop;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign w_rbin_sync = gray2bin(r_rgray_s2);
  assign o_wrusedw   = r_wbin - w_rbin_sync;
  assign o_wrfull    = (o_wrusedw == (AW+1)'(DEPTH));
  assign o_wrempty   = (r_wgray == r_rgray_s2);
  assign w_push      = i_wrreq && !o_wrfull;
  assign w_wbin_nxt  = r_wbin + (AW+1)'(w_push);

  assign o_rdempty   = (r_rgray == r_wgray_s2);
  assign w_pop       = i_rdreq && !o_rdempty;
  assign w_rbin_nxt  = r_rbin + (AW+1)'(w_pop);
  assign o_q         = r_mem[r_rbin[AW-1:0]];

  // Storage write port.
  always_ff @(posedge i_wrclk) begin
    if (w_push) r_mem[r_wbin[AW-1:0]] <= i_data;
  end

  // Write pointer and read-pointer synchroniser.
  always_ff @(posedge i_wrclk or posedge i_aclr) begin
    if (i_aclr) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_rgray_s1 <= '0;
      r_rgray_s2 <= '0;
    end else begin
      r_wbin     <= w_wbin_nxt;
      r_wgray    <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
      r_rgray_s1 <= r_rgray;
      r_rgray_s2 <= r_rgray_s1;
    end
  end

  // Read pointer and write-pointer synchroniser.
  always_ff @(posedge i_rdclk or posedge i_aclr) begin
    if (i_aclr) begin
      r_rbin     <= '0;
      r_rgray    <= '0;
      r_wgray_s1 <= '0;
      r_wgray_s2 <= '0;
    end else begin
      r_rbin     <= w_rbin_nxt;
      r_rgray    <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
      r_wgray_s1 <= r_wgray;
      r_wgray_s2 <= r_wgray_s1;
    end
  end

endmodule

// File: rtl/shift_reg.sv
// Fixed-depth delay line with async clear; aligns request info with RAM read data.
module shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per clock; stage 0 takes the new input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/tile_addr_gen.sv
// Row/column walker for one job: tile-RAM index and framebuffer byte address.
module tile_addr_gen
  import gpu_tile_pkg::*;
#(
  parameter  int TILE_W = 16,
  parameter  int TILE_H = 32,
  parameter  int ADDR_W = 32,
  localparam int CW     = $clog2(TILE_W),
  localparam int CCW    = $clog2(TILE_W) + 1,
  localparam int RCW    = $clog2(TILE_H) + 1,
  localparam int RAW    = $clog2(TILE_W * TILE_H)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [15:0]       i_stride,
  input  logic [CCW-1:0]    i_clip_cols,
  input  logic [RCW-1:0]    i_clip_rows,
  output logic [RAW-1:0]    o_ram_addr,
  output logic [ADDR_W-1:0] o_cur_addr,
  output logic              o_row_done,
  output logic              o_job_done
);

  logic [CW-1:0]     r_col;
  logic [RCW-1:0]    r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic [15:0]       r_stride;
  logic [CCW-1:0]    r_cols;
  logic [RCW-1:0]    r_rows;

  // TILE_W is a power of two, so row*TILE_W+col is a plain concatenation.
  assign o_ram_addr = RAW'({r_row, r_col});
  assign o_cur_addr = r_row_base + ADDR_W'(32'(r_col) * BYTES_PER_WORD);
  assign o_row_done = (CCW'(r_col) == r_cols - CCW'(1));
  assign o_job_done = (r_cols == '0) || (r_rows == '0) || (r_row == r_rows);

  // Latch job geometry on load; walk columns then rows on each step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_stride   <= '0;
      r_cols     <= '0;
      r_rows     <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= i_base;
      r_stride   <= i_stride;
      r_cols     <= i_clip_cols;
      r_rows     <= i_clip_rows;
    end else if (i_step) begin
      if (o_row_done) begin
        r_col      <= '0;
        r_row      <= r_row + RCW'(1);
        r_row_base <= r_row_base + ADDR_W'(r_stride);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tile_flush_engine.sv
// Tile flush engine: reads a (clipped) tile from tile RAM in gpu_clk, ships
// {addr, be, data} words through a dual-clock FIFO, and writes them over an
// Avalon-MM master in clk. One job can be queued while another runs.
module tile_flush_engine
  import gpu_tile_pkg::*;
#(
  parameter int TILE_W     = 16,
  parameter int TILE_H     = 32,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 32
) (
  input  logic                              gpu_clk,
  input  logic                              gpu_rst,
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 addr_in,
  input  logic [15:0]                       stride_in,
  input  logic [$clog2(TILE_W):0]           clip_cols_in,
  input  logic [$clog2(TILE_H):0]           clip_rows_in,
  input  logic [3:0]                        be_in,
  output logic                              busy,
  output logic                              accept,
  output logic                              flushed,
  output logic [$clog2(TILE_W*TILE_H)-1:0]  ram_addr_out,
  input  logic [31:0]                       ram_data,
  output logic [ADDR_W-1:0]                 master_address,
  output logic                              master_write,
  output logic [31:0]                       master_writedata,
  output logic [3:0]                        master_byteenable,
  input  logic                              master_waitrequest
);

  localparam int CCW = $clog2(TILE_W) + 1;
  localparam int RCW = $clog2(TILE_H) + 1;
  localparam int RAW = $clog2(TILE_W * TILE_H);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FW  = fifo_word_w(ADDR_W);
  localparam int PW  = 1 + 4 + ADDR_W;
  // Enough room for a whole row plus reads still in the RAM pipe.
  localparam logic [FAW:0] ROOM = (FAW+1)'(FIFO_DEPTH - TILE_W - RAM_LAT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [15:0]       r_pend_stride;
  logic [CCW-1:0]    r_pend_cols;
  logic [RCW-1:0]    r_pend_rows;
  logic [3:0]        r_pend_be;
  logic [3:0]        r_be;
  logic              r_rd_en;

  logic              w_load, w_step, w_row_done, w_job_done;
  logic [RAW-1:0]    w_ram_addr;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [PW-1:0]     w_pipe_q;
  logic [FAW:0]      w_wrusedw;
  logic              w_wrfull, w_wrempty, w_rdempty, w_rdreq;
  logic [FW-1:0]     w_fifo_q;

  assign w_load       = (r_state == S_IDLE) && r_pend_valid;
  assign accept       = !r_pend_valid;
  assign busy         = (r_state != S_IDLE) || r_pend_valid;
  assign flushed      = !busy && w_wrempty;
  assign ram_addr_out = (r_state == S_ROW) ? w_ram_addr : '0;

  // State register.
  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and per-cycle read strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE:  if (r_pend_valid) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_job_done ? S_IDLE : S_WAIT;
      S_WAIT:  if ((w_wrusedw <= ROOM) && !w_wrfull) w_state_nxt = S_ROW;
      S_ROW: begin
        w_step = 1'b1;
        if (w_row_done) w_state_nxt = S_CHECK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-entry pending slot: filled by an accepted start, emptied when IDLE launches it.
  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_addr   <= '0;
      r_pend_stride <= '0;
      r_pend_cols   <= '0;
      r_pend_rows   <= '0;
      r_pend_be     <= '0;
    end else if (start && !r_pend_valid) begin
      r_pend_valid  <= 1'b1;
      r_pend_addr   <= addr_in;
      r_pend_stride <= stride_in;
      r_pend_cols   <= clip_cols_in;
      r_pend_rows   <= clip_rows_in;
      r_pend_be     <= be_in;
    end else if (w_load) begin
      r_pend_valid  <= 1'b0;
    end
  end

  // Byte-enable of the active job.
  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst)     r_be <= '0;
    else if (w_load) r_be <= r_pend_be;
  end

  tile_addr_gen #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk       (gpu_clk),
    .i_rst       (gpu_rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_base      (r_pend_addr),
    .i_stride    (r_pend_stride),
    .i_clip_cols (r_pend_cols),
    .i_clip_rows (r_pend_rows),
    .o_ram_addr  (w_ram_addr),
    .o_cur_addr  (w_cur_addr),
    .o_row_done  (w_row_done),
    .o_job_done  (w_job_done)
  );

  // be travels with each word so a back-to-back job cannot relabel words still in flight.
  shift_reg #(
    .WIDTH (PW),
    .DEPTH (RAM_LAT)
  ) u_pipe (
    .i_clk (gpu_clk),
    .i_rst (gpu_rst),
    .i_d   ({w_step, r_be, w_cur_addr}),
    .o_q   (w_pipe_q)
  );

  dc_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_aclr    (gpu_rst),
    .i_wrclk   (gpu_clk),
    .i_wrreq   (w_pipe_q[PW-1]),
    .i_data    ({w_pipe_q[ADDR_W-1:0], w_pipe_q[ADDR_W+3:ADDR_W], ram_data}),
    .o_wrusedw (w_wrusedw),
    .o_wrfull  (w_wrfull),
    .o_wrempty (w_wrempty),
    .i_rdclk   (clk),
    .i_rdreq   (w_rdreq),
    .o_q       (w_fifo_q),
    .o_rdempty (w_rdempty)
  );

  // Holds the bus master idle while the clk domain is in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_en <= 1'b0;
    else     r_rd_en <= 1'b1;
  end

  assign master_write      = r_rd_en && !w_rdempty;
  assign w_rdreq           = master_write && !master_waitrequest;
  assign master_address    = w_fifo_q[FW-1 -: ADDR_W];
  assign master_byteenable = w_fifo_q[35:32];
  assign master_writedata  = w_fifo_q[31:0];

endmodule
